instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 19 +
 rtl/instr_loader_if.sv | 26 ++
 rtl/instr_loader_byte_packer.sv | 34 +++
 rtl/instr_loader.sv | 140 ++++++++++++++
 tb/tb_instr_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// LOADER_CHECKSUM_EN adds the CHECK state used by the trailing checksum byte.
`timescale 1ns/1ps
package instr_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory store bus of the loader.
// master = the loader, slave = byte source / instruction memory side.
`timescale 1ns/1ps
interface instr_loader_if #(
    parameter int ADDR_W = 6
);
    import instr_loader_pkg::*;

    logic [BYTE_W-1:0]  byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               store_en;
    logic [ADDR_W-1:0]  store_address;
    logic [INSTR_W-1:0] store_data;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, store_en, store_address, store_data
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, store_en, store_address, store_data
    );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word assembler: first byte lands in [7:0].
// word/word_valid are combinational so the word is usable on the fourth accepting edge.
`timescale 1ns/1ps
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]                byte_idx_q;
    logic [INSTR_W-BYTE_W-1:0] shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q <= '0;
            shift_q    <= '0;
        end else if (clear) begin
            byte_idx_q <= '0;
        end else if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            shift_q    <= {byte_in, shift_q[INSTR_W-BYTE_W-1:BYTE_W]};
        end
    end

    assign word_valid = accept && (byte_idx_q == 2'd3);
    assign word       = {byte_in, shift_q};

endmodule

// File: rtl/instr_loader.sv
// Serial-byte instruction loader: writes len words into instruction memory, holding the core.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
`timescale 1ns/1ps
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_start,
    input  logic [6:0]     load_len,
    input  logic           load_abort,
    instr_loader_if.master bus,
    output logic           core_hold,
    output logic           load_busy,
    output logic           load_done,
    output logic           load_err
);

    localparam int LEN_W = ADDR_W + 1;

    loader_state_t      state_q, state_d;
    logic [LEN_W-1:0]   len_q, word_cnt_q, len_clamped;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] data_q;
    logic               start_ok, abort_now, pack_accept, pack_clear;
    logic               word_valid, byte_ready, store_en;
    logic [INSTR_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  xor_q;
`endif

    assign len_clamped = (32'(load_len) > DEPTH) ? LEN_W'(DEPTH) : LEN_W'(load_len);
    assign abort_now   = load_abort && (state_q != IDLE);
    // Kept independent of byte_ready so the packer's word_valid feeds the FSM without a loop.
    assign pack_accept = (state_q == COLLECT) && bus.byte_valid && !load_abort;
    assign pack_clear  = start_ok || abort_now;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .accept     (pack_accept),
        .byte_in    (bus.byte_in),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        store_en   = 1'b0;
        load_done  = 1'b0;
        start_ok   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start && (load_len != '0)) begin
                    start_ok = 1'b1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                byte_ready = 1'b1;
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                store_en = 1'b1;
                if ((word_cnt_q + LEN_W'(1)) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) state_d = (bus.byte_in == xor_q) ? DONE : IDLE;
            end
`endif
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_now) begin
            state_d   = IDLE;
            store_en  = 1'b0;
            load_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                len_q      <= len_clamped;
                word_cnt_q <= '0;
                load_err   <= 1'b0;
            end
            // Address/data registered on the assembling edge so they stay put outside WRITE.
            if (word_valid) begin
                addr_q <= word_cnt_q[ADDR_W-1:0];
                data_q <= word;
            end
            if ((state_q == WRITE) && !load_abort) word_cnt_q <= word_cnt_q + LEN_W'(1);
            if (abort_now) load_err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (start_ok) xor_q <= '0;
            else if (pack_accept) xor_q <= xor_q ^ bus.byte_in;
            if ((state_q == CHECK) && bus.byte_valid && !load_abort && (bus.byte_in != xor_q))
                load_err <= 1'b1;
`endif
        end
    end

    assign load_busy         = (state_q != IDLE);
    assign core_hold         = load_busy;
    assign bus.byte_ready    = byte_ready;
    assign bus.store_en      = store_en;
    assign bus.store_address = addr_q;
    assign bus.store_data    = data_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed scoreboard bench for instr_loader; expected stores are queued as bytes are driven.
`timescale 1ns/1ps
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic       load_abort = 1'b0;
    logic [6:0] load_len = '0;
    logic       core_hold, load_busy, load_done, load_err;
    logic [7:0] ck;

    exp_t        sb[$];
    int unsigned tests = 0, fails = 0, cyc = 0;
    int unsigned n_store = 0, n_done = 0, last_store_cyc = 0, done_cyc = 0, last_addr = 0;

    instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .load_abort (load_abort),
        .bus        (bus.master),
        .core_hold  (core_hold),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.store_en === 1'b1) begin
            n_store++;
            last_store_cyc = cyc;
            last_addr      = 32'(bus.store_address);
            check("store_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("store_addr", 32'(bus.store_address), 32'(e.addr));
                check("store_data", bus.store_data, e.data);
            end
        end
        if (load_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [6:0] len);
        ck         = '0;
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ck = ck ^ w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic send_check();
`ifdef LOADER_CHECKSUM_EN
        send_byte(ck);
`endif
    endtask

    task automatic wait_done(input string tag, input int unsigned prev);
        int unsigned n = 0;
        while (n_done == prev && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, n_done, prev + 1);
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_store_en"}, 32'(bus.store_en), 32'd0);
        check({tag, "_store_addr"}, 32'(bus.store_address), 32'd0);
        check({tag, "_store_data"}, bus.store_data, 32'd0);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_busy"}, 32'(load_busy), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, s0;
        logic [31:0] w;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        // reset state
        #1 reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        tick();
        reset = 1'b0;
        tick();

        // zero length is ignored
        start(7'd0);
        check("len0_busy", 32'(load_busy), 32'd0);

        // two-word load
        sb.push_back('{addr: 6'd0, data: 32'h0000_0013});
        sb.push_back('{addr: 6'd1, data: 32'h0010_0093});
        d0 = n_done;
        start(7'd2);
        check("t1_busy", 32'(load_busy), 32'd1);
        check("t1_core_hold", 32'(core_hold), 32'd1);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_check();
        wait_done("t1_done", d0);
`ifndef LOADER_CHECKSUM_EN
        check("t1_done_latency", done_cyc - last_store_cyc, 32'd1);
`endif
        check("t1_busy_after", 32'(load_busy), 32'd0);
        check("t1_err", 32'(load_err), 32'd0);
        check("t1_sb_empty", sb.size(), 32'd0);

        // oversize length clamps to DEPTH
        d0 = n_done;
        s0 = n_store;
        start(7'd100);
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            sb.push_back('{addr: ADDR_W'(i), data: w});
            send_word(w);
        end
        send_check();
        wait_done("t2_done", d0);
        check("t2_writes", n_store - s0, 32'(DEPTH));
        check("t2_last_addr", last_addr, 32'(DEPTH - 1));
        check("t2_busy_after", 32'(load_busy), 32'd0);

        // byte_valid stall mid-word
        d0 = n_done;
        start(7'd1);
        sb.push_back('{addr: 6'd0, data: 32'hCAFE_BABE});
        ck = 8'hBE ^ 8'hBA ^ 8'hFE ^ 8'hCA;
        send_byte(8'hBE);
        send_byte(8'hBA);
        s0 = n_store;
        repeat (10) tick();
        check("t3_stall_no_store", n_store, s0);
        check("t3_stall_busy", 32'(load_busy), 32'd1);
        send_byte(8'hFE);
        send_byte(8'hCA);
        send_check();
        wait_done("t3_done", d0);

        // abort after two bytes
        d0 = n_done;
        start(7'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        s0 = n_store;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_busy", 32'(load_busy), 32'd0);
        check("t4_core_hold", 32'(core_hold), 32'd0);
        repeat (3) tick();
        check("t4_no_store", n_store, s0);
        check("t4_no_done", n_done, d0);

        // abort coinciding with WRITE suppresses the store; new start clears err
        start(7'd1);
        check("t4b_err_cleared", 32'(load_err), 32'd0);
        send_word(32'h5566_7788);
        s0 = n_store;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        repeat (3) tick();
        check("t4b_no_store", n_store, s0);
        check("t4b_no_done", n_done, d0);
        check("t4b_err", 32'(load_err), 32'd1);

        // reset mid-word
        start(7'd1);
        send_byte(8'hA1);
        send_byte(8'hA2);
        d0 = n_done;
        s0 = n_store;
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("t5_reset");
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t5_no_done", n_done, d0);
        check("t5_no_store", n_store, s0);
        check("t5_idle", 32'(load_busy), 32'd0);
        sb.push_back('{addr: 6'd0, data: 32'h1234_5678});
        start(7'd1);
        send_word(32'h1234_5678);
        send_check();
        wait_done("t5_reload_done", d0);

`ifdef LOADER_CHECKSUM_EN
        // checksum match and mismatch
        d0 = n_done;
        sb.push_back('{addr: 6'd0, data: 32'h0403_0201});
        start(7'd1);
        send_word(32'h0403_0201);
        send_byte(8'h04);
        wait_done("t6_ck_ok_done", d0);
        check("t6_ck_ok_err", 32'(load_err), 32'd0);
        d0 = n_done;
        sb.push_back('{addr: 6'd0, data: 32'h0403_0201});
        start(7'd1);
        send_word(32'h0403_0201);
        send_byte(8'h05);
        repeat (3) tick();
        check("t6_ck_bad_err", 32'(load_err), 32'd1);
        check("t6_ck_bad_no_done", n_done, d0);
        check("t6_ck_bad_busy", 32'(load_busy), 32'd0);
`endif

        check("final_sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
